// File: rtl/dma_copy.sv
// Word-granular memory-to-memory copy/fill engine; initiator on the valid/ready memory bus.
// One command at a time, alternating read/write transactions, with abort at transaction boundaries.
module dma_copy #(
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [31:0]         cmd_src,
    input  logic [31:0]         cmd_dst,
    input  logic [LEN_BITS-1:0] cmd_len,
    input  logic                cmd_fill,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [LEN_BITS-1:0] remaining,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [31:0]         mem_addr,
    input  logic [31:0]         mem_rdata,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wstrb
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

    state_t              state, state_n;
    logic [31:0]         src, src_n, dst, dst_n, data, data_n;
    logic                fill, fill_n, abort_q, abort_n;
    logic [LEN_BITS-1:0] rem_n;
    logic                valid_n;
    logic [31:0]         addr_n, wdata_n;
    logic [3:0]          wstrb_n;

    always_comb begin
        state_n = state;
        src_n   = src;
        dst_n   = dst;
        data_n  = data;
        fill_n  = fill;
        rem_n   = remaining;
        abort_n = abort_q | ((state != IDLE) && abort);
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    // In fill mode src carries the pattern, so it is kept unaligned.
                    src_n   = cmd_fill ? cmd_src : {cmd_src[31:2], 2'b00};
                    dst_n   = {cmd_dst[31:2], 2'b00};
                    rem_n   = cmd_len;
                    fill_n  = cmd_fill;
                    abort_n = 1'b0;
                    if (cmd_len == '0)  state_n = FINISH;
                    else if (cmd_fill)  state_n = WRITE;
                    else                state_n = READ;
                end
            end
            READ: begin
                if (mem_ready) begin
                    data_n  = mem_rdata;
                    src_n   = src + 32'd4;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    dst_n = dst + 32'd4;
                    rem_n = remaining - LEN_BITS'(1);
                    if (rem_n == '0 || abort_n) state_n = FINISH;
                    else if (fill)              state_n = WRITE;
                    else                        state_n = READ;
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Bus outputs are computed from the next state so they can be registered.
        valid_n = (state_n == READ) || (state_n == WRITE);
        addr_n  = '0;
        wdata_n = '0;
        wstrb_n = '0;
        if (state_n == READ) addr_n = src_n;
        if (state_n == WRITE) begin
            addr_n  = dst_n;
            wdata_n = fill_n ? src_n : data_n;
            wstrb_n = 4'hF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            data      <= '0;
            fill      <= 1'b0;
            abort_q   <= 1'b0;
            remaining <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_n;
            src       <= src_n;
            dst       <= dst_n;
            data      <= data_n;
            fill      <= fill_n;
            abort_q   <= abort_n;
            remaining <= rem_n;
            mem_valid <= valid_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_wstrb <= wstrb_n;
            done      <= (state_n == FINISH);
            aborted   <= (state_n == FINISH) && abort_n;
            busy      <= (state_n != IDLE);
            cmd_ready <= (state_n == IDLE);
        end
    end

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: RAM-like responder with programmable wait states, bus log,
// and immediate-assertion checks against hand-computed expectations.
module tb_dma_copy;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_fill, abort;
    logic [31:0] cmd_src, cmd_dst;
    logic [15:0] cmd_len, remaining;
    logic        busy, done, aborted;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_rdata, mem_wdata;
    logic [3:0]  mem_wstrb;

    dma_copy #(.LEN_BITS(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted), .remaining(remaining),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    string tname = "";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed %h expected %h", tname, tag, obs, exp);
        end
    endtask

    // Memory: word i initialised to 0xA0000000 + i, indexed by addr[9:2].
    logic [31:0] mem [256];
    int          wait_n = 0;
    int          wcnt = 0;
    int          done_cnt = 0;
    logic [31:0] lg_addr [$];
    logic [31:0] lg_data [$];
    logic [3:0]  lg_strb [$];

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!rst) begin
            mem_ready <= 1'b0;
            wcnt      <= 0;
        end else if (mem_ready) begin
            mem_ready <= 1'b0;
        end else if (mem_valid) begin
            if (wcnt >= wait_n) begin
                mem_ready <= 1'b1;
                wcnt      <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst && mem_valid && mem_ready) begin
            lg_addr.push_back(mem_addr);
            lg_strb.push_back(mem_wstrb);
            lg_data.push_back(mem_wstrb != 4'h0 ? mem_wdata : mem_rdata);
            if (mem_wstrb != 4'h0) mem[mem_addr[9:2]] <= mem_wdata;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // Held request must not change while waiting for mem_ready.
    logic        p_v = 1'b0, p_r = 1'b0;
    logic [31:0] p_a = '0, p_d = '0;
    logic [3:0]  p_s = '0;
    always @(negedge clk) begin
        if (rst && p_v && !p_r && mem_valid) begin
            chk("hold.addr", mem_addr, p_a);
            chk("hold.wdata", mem_wdata, p_d);
            chk("hold.wstrb", {28'd0, mem_wstrb}, {28'd0, p_s});
        end
        p_v = mem_valid; p_r = mem_ready;
        p_a = mem_addr;  p_d = mem_wdata; p_s = mem_wstrb;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base;

    task automatic start(input logic [31:0] s, d, input logic [15:0] l, input logic f);
        @(negedge clk);
        base = lg_addr.size();
        cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_len = l; cmd_fill = f;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Returns the negedge index (1 = cycle after accept) at which done was seen.
    task automatic run(input logic [31:0] s, d, input logic [15:0] l, input logic f,
                       input int abort_at, output int k);
        start(s, d, l, f);
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            abort = (k == abort_at);
            if (done) break;
        end
        abort = 1'b0;
    endtask

    task automatic txn(input int i, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] oa, od;
        logic [3:0]  os;
        oa = (base + i < lg_addr.size()) ? lg_addr[base+i] : 32'hxxxx_xxxx;
        od = (base + i < lg_addr.size()) ? lg_data[base+i] : 32'hxxxx_xxxx;
        os = (base + i < lg_addr.size()) ? lg_strb[base+i] : 4'hx;
        chk($sformatf("t%0d.addr", i), oa, a);
        chk($sformatf("t%0d.strb", i), {28'd0, os}, {28'd0, s});
        chk($sformatf("t%0d.data", i), od, d);
    endtask

    task automatic copy3(input logic [31:0] dst, input int exp_k);
        int k, dc;
        dc = done_cnt;
        run(32'h100, dst, 16'd3, 1'b0, 0, k);
        chk("done_cycle", k, exp_k);
        chk("remaining", {16'd0, remaining}, 32'd0);
        chk("aborted", {31'd0, aborted}, 32'd0);
        chk("ready_at_done", {31'd0, cmd_ready}, 32'd0);
        chk("n_txn", lg_addr.size() - base, 32'd6);
        txn(0, 32'h100, 4'h0, 32'hA000_0040);
        txn(1, dst,     4'hF, 32'hA000_0040);
        txn(2, 32'h104, 4'h0, 32'hA000_0041);
        txn(3, dst + 4, 4'hF, 32'hA000_0041);
        txn(4, 32'h108, 4'h0, 32'hA000_0042);
        txn(5, dst + 8, 4'hF, 32'hA000_0042);
        @(negedge clk);
        chk("done_pulses", done_cnt - dc, 32'd1);
        chk("done_low", {31'd0, done}, 32'd0);
        chk("ready_back", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        rst = 1'b0; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0;
        cmd_len = '0; cmd_fill = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);

        tname = "reset";
        chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("busy", {31'd0, busy}, 32'd0);
        chk("done", {31'd0, done}, 32'd0);
        chk("mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("mem_addr", mem_addr, 32'd0);
        chk("mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("remaining", {16'd0, remaining}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        tname = "copy3";
        wait_n = 0;
        copy3(32'h200, 13);

        tname = "fill4";
        run(32'hDEAD_BEEF, 32'h13, 16'd4, 1'b1, 0, k);
        chk("done_cycle", k, 32'd9);
        chk("n_txn", lg_addr.size() - base, 32'd4);
        txn(0, 32'h10, 4'hF, 32'hDEAD_BEEF);
        txn(1, 32'h14, 4'hF, 32'hDEAD_BEEF);
        txn(2, 32'h18, 4'hF, 32'hDEAD_BEEF);
        txn(3, 32'h1C, 4'hF, 32'hDEAD_BEEF);
        chk("remaining", {16'd0, remaining}, 32'd0);

        tname = "len0";
        run(32'h100, 32'h200, 16'd0, 1'b0, 0, k);
        chk("done_cycle", k, 32'd1);
        chk("aborted", {31'd0, aborted}, 32'd0);
        chk("mem_valid", {31'd0, mem_valid}, 32'd0);
        @(negedge clk);
        chk("n_txn", lg_addr.size() - base, 32'd0);
        chk("ready_back", {31'd0, cmd_ready}, 32'd1);

        tname = "wait3";
        wait_n = 3;
        copy3(32'h300, 31);
        wait_n = 0;

        tname = "abort";
        run(32'h100, 32'h380, 16'd8, 1'b0, 9, k);
        chk("done_cycle", k, 32'd13);
        chk("aborted", {31'd0, aborted}, 32'd1);
        chk("remaining", {16'd0, remaining}, 32'd5);
        chk("n_txn", lg_addr.size() - base, 32'd6);
        txn(4, 32'h108, 4'h0, 32'hA000_0042);
        txn(5, 32'h388, 4'hF, 32'hA000_0042);
        @(negedge clk);

        tname = "rst_mid";
        start(32'h100, 32'h200, 16'd3, 1'b0);
        repeat (3) @(negedge clk);
        chk("in_write", {28'd0, mem_wstrb}, 32'hF);
        rst = 1'b0;
        #1;
        chk("mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        tname = "wrap";
        run(32'hFFFF_FFFC, 32'h40, 16'd2, 1'b0, 0, k);
        chk("done_cycle", k, 32'd9);
        chk("n_txn", lg_addr.size() - base, 32'd4);
        txn(0, 32'hFFFF_FFFC, 4'h0, 32'hA000_00FF);
        txn(1, 32'h40,        4'hF, 32'hA000_00FF);
        txn(2, 32'h0,         4'h0, 32'hA000_0000);
        txn(3, 32'h44,        4'hF, 32'hA000_0000);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dma_copy.md
# dma_copy

Word-granular memory-to-memory copy/fill engine that acts as an initiator on the SoC's valid/ready memory bus, the same bus that the CPU drives and that RAM and external memory answer. It accepts one command at a time (source, destination, word count, mode) and issues alternating read/write transactions until the count is exhausted or an abort is requested. It then pulses `done`. It sits beside the CPU behind a bus arbiter and is configured by a CPU-side register shim; both of those are outside this block.

## Interface
- `LEN_BITS`, default 16: width of the word-count field; maximum transfer is 2^LEN_BITS−1 words.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  engine idle and able to accept a command.
- `cmd_src`  in  32  source byte address (copy mode) or fill pattern (fill mode).
- `cmd_dst`  in  32  destination byte address.
- `cmd_len`  in  LEN_BITS  number of 32-bit words.
- `cmd_fill`  in  1  1 = fill `cmd_dst` region with `cmd_src` value; no reads.
- `abort`  in  1  level; stop at the next transaction boundary.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse at command completion.
- `aborted`  out  1  valid with `done`; 1 if the command ended early.
- `remaining`  out  LEN_BITS  words not yet written.
- `mem_valid`  out  1  bus request.
- `mem_ready`  in  1  responder completion strobe.
- `mem_addr`  out  32  word-aligned byte address; bits [1:0] always 0.
- `mem_rdata`  in  32  read data, sampled when `mem_valid && mem_ready`.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  4'b0000 for a read, 4'b1111 for a write.

## Operation
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `aborted`=0, `remaining`=0, `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0. The engine enters this state immediately on `rst`=0, including mid-transaction. A dropped `mem_valid` there is the only permitted protocol break.
- States: IDLE, READ, WRITE, FINISH.
- IDLE: if `cmd_valid`, latch src/dst with bits [1:0] cleared (the pattern is latched unmodified in fill mode), and latch len, fill and `remaining`=len. Clear the abort latch. Next state:
  - FINISH if len=0;
  - WRITE if fill=1;
  - READ otherwise.
- READ: `mem_valid`=1, `mem_addr`=src, `mem_wstrb`=0. On `mem_ready`, capture `mem_rdata` into the data register, src += 4, and go to WRITE.
- WRITE: `mem_valid`=1, `mem_addr`=dst, `mem_wdata`=data register (or the pattern when fill=1), `mem_wstrb`=4'b1111. On `mem_ready`: dst += 4 and `remaining` −= 1. Then:
  - if new `remaining`=0, or the abort latch is set, go to FINISH;
  - otherwise go to READ (copy) or WRITE (fill).
- FINISH: `done`=1 and `aborted`=abort latch for exactly one cycle, then IDLE.
- The abort latch is set by `abort`=1 in any non-IDLE state. It never drops `mem_valid` early. A READ in flight still completes, along with its paired WRITE, so no word is read without being written.
- Address arithmetic is modulo 2^32: 0xFFFFFFFC + 4 = 0x00000000. No error is raised.
- `busy` is 1 in READ, WRITE and FINISH. `cmd_ready` = IDLE.

## Timing
- All outputs are registered.
- Bus rule: once `mem_valid` rises, `mem_addr`, `mem_wdata` and `mem_wstrb` are held stable until the cycle `mem_ready` is sampled high.
- In the cycle after `mem_ready`, either `mem_valid` is 0, or a new transaction is presented with new address/strobe. The engine never re-presents the completed transaction.
- Command accepted at edge T: `mem_valid` is high in the cycle after T.
- With a responder answering one cycle after `mem_valid`, such as on-chip RAM:
  - copy costs 4 cycles per word (2 for the read, 2 for the write);
  - fill costs 2 cycles per word.
- `done` rises in the cycle after the last write's `mem_ready`. `cmd_ready` returns in the following cycle.
- len=0: `done` is high in cycle T+1 with no bus activity.
- `cmd_valid` while busy is ignored, not queued.
- Responder wait states of any length are tolerated. There is no timeout.

## Test plan
- Copy, len=3, src=0x100, dst=0x200, 1-cycle responder. Expected: bus sequence R100, W200, R104, W204, R108, W208; written data equals the read data; `done` pulses once 12 cycles after the first `mem_valid`; `remaining` = 0.
- Fill, len=4, pattern 0xDEADBEEF, dst=0x13 → writes to 0x10, 0x14, 0x18, 0x1C, all with wstrb=4'hF; no reads; 8 bus cycles.
- len=0 → `done`=1, `aborted`=0 one cycle after accept; `mem_valid` never rises.
- Responder inserts 3 wait cycles per transaction → addr, wdata and wstrb stay constant while `mem_valid` and not `mem_ready`; the result matches the zero-wait run.
- Copy len=8 with `abort` pulsed during the 3rd READ → the 3rd read and its write complete, no 4th read; `done` with `aborted`=1; `remaining`=5.
- `rst` pulled low mid-WRITE → `mem_valid`=0 and `cmd_ready`=1 immediately. Wrap check: src=0xFFFFFFFC, len=2 → reads 0xFFFFFFFC then 0x00000000.
